// File: rtl/hex_word_parser.sv
// Assembles delimiter-terminated runs of ASCII hex digits into binary words.
// One result per token, with a byte valid/ready input and a word valid/ready output.
module hex_word_parser #(
  parameter int WORD_DIGITS = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [7:0]                           in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [4*WORD_DIGITS-1:0]             out_word,
  output logic [$clog2(WORD_DIGITS+1)-1:0]     out_ndigits,
  output logic                                 out_error,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int CW = $clog2(WORD_DIGITS + 1);
  localparam int WW = 4 * WORD_DIGITS;
  localparam logic [CW-1:0] MAX_COUNT = CW'(WORD_DIGITS);
  localparam logic [CW-1:0] ONE_COUNT = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SKIP, ST_EMIT} state_t;
  typedef enum logic [1:0] {CLS_DIGIT, CLS_DELIM, CLS_INVALID} char_cls_t;

  state_t          r_state, w_state_next;
  logic [WW-1:0]   r_acc, w_acc_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_err, w_err_next;
  logic [WW-1:0]   r_out_word;
  logic [CW-1:0]   r_out_ndigits;
  logic            r_out_error;

  char_cls_t       w_cls;
  logic [3:0]      w_nibble;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_out;

  // Letters 'a'-'f' and 'A'-'F' both have low nibble 1..6, so +9 maps them to 10..15.
  always_comb begin
    w_cls    = CLS_INVALID;
    w_nibble = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      w_cls    = CLS_DIGIT;
      w_nibble = in_data[3:0];
    end else if ((in_data >= 8'h61 && in_data <= 8'h66) ||
                 (in_data >= 8'h41 && in_data <= 8'h46)) begin
      w_cls    = CLS_DIGIT;
      w_nibble = in_data[3:0] + 4'd9;
    end else if (in_data == 8'h20 || in_data == 8'h0D ||
                 in_data == 8'h0A || in_data == 8'h2C) begin
      w_cls    = CLS_DELIM;
    end
  end

  assign in_ready   = reset && (r_state != ST_EMIT);
  assign out_valid  = (r_state == ST_EMIT);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_load_out = (r_state != ST_EMIT) && (w_state_next == ST_EMIT);

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_err_next   = r_err;
    unique case (r_state)
      ST_IDLE: if (w_in_fire) begin
        if (w_cls == CLS_DIGIT) begin
          w_acc_next   = {{(WW-4){1'b0}}, w_nibble};
          w_count_next = ONE_COUNT;
          w_state_next = ST_ACCUM;
        end else if (w_cls == CLS_INVALID) begin
          w_err_next   = 1'b1;
          w_state_next = ST_SKIP;
        end
      end
      ST_ACCUM: if (w_in_fire) begin
        if (w_cls == CLS_DELIM) begin
          w_state_next = ST_EMIT;
        end else if (w_cls == CLS_DIGIT && r_count != MAX_COUNT) begin
          w_acc_next   = {r_acc[WW-5:0], w_nibble};
          w_count_next = r_count + ONE_COUNT;
        end else begin
          w_err_next   = 1'b1;
          w_state_next = ST_SKIP;
        end
      end
      ST_SKIP: if (w_in_fire && w_cls == CLS_DELIM) begin
        w_state_next = ST_EMIT;
      end
      ST_EMIT: if (w_out_fire) begin
        w_acc_next   = '0;
        w_count_next = '0;
        w_err_next   = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_count       <= '0;
      r_err         <= 1'b0;
      r_out_word    <= '0;
      r_out_ndigits <= '0;
      r_out_error   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_err   <= w_err_next;
      if (w_load_out) begin
        r_out_word    <= w_err_next ? '0 : w_acc_next;
        r_out_ndigits <= w_err_next ? '0 : w_count_next;
        r_out_error   <= w_err_next;
      end else if (w_out_fire) begin
        r_out_word    <= '0;
        r_out_ndigits <= '0;
        r_out_error   <= 1'b0;
      end
    end
  end

  assign out_word    = r_out_word;
  assign out_ndigits = r_out_ndigits;
  assign out_error   = r_out_error;

endmodule

// File: tb/tb_hex_word_parser.sv
// Directed bench for hex_word_parser: token parsing, overflow, invalid bytes,
// output back-pressure, delimiter-only input and reset mid-token / mid-result.
module tb_hex_word_parser;

  localparam int WORD_DIGITS = 8;
  localparam int CW = $clog2(WORD_DIGITS + 1);

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic [7:0]               in_data = 8'h00;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [4*WORD_DIGITS-1:0] out_word;
  logic [CW-1:0]            out_ndigits;
  logic                     out_error;
  logic                     out_valid;
  logic                     out_ready = 1'b1;

  typedef struct packed {
    logic [4*WORD_DIGITS-1:0] word;
    logic [CW-1:0]            nd;
    logic                     err;
  } result_t;

  result_t q[$];
  result_t r;
  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  int valid_cycles = 0;

  hex_word_parser #(.WORD_DIGITS(WORD_DIGITS)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_ndigits(out_ndigits),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // Inputs change at posedge+1, so the negedge view is what the next posedge will see.
  always @(negedge clock) begin
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) q.push_back('{word: out_word, nd: out_ndigits, err: out_error});
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waited < 50) begin
      waited++;
      stall_cycles++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b expected 1", b, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_results(input int n);
    int cyc = 0;
    while (q.size() < n && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic take(output result_t res);
    if (q.size() > 0) res = q.pop_front();
    else res = '1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_word !== '0) begin errors++; $display("FAIL rst_word got %h want 0", out_word); end
    checks++; if (out_ndigits !== '0 || out_error !== 1'b0) begin errors++; $display("FAIL rst_nd_err got %0d/%b want 0/0", out_ndigits, out_error); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    q.delete();
    send_str("1A2b");
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    send_byte(8'h0A);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", out_valid); end
    wait_results(1);
    take(r);
    checks++; if (r.word !== 32'h00001A2B) begin errors++; $display("FAIL basic_word got %h want 00001a2b", r.word); end
    checks++; if (r.nd !== 4'd4 || r.err !== 1'b0) begin errors++; $display("FAIL basic_nd_err got %0d/%b want 4/0", r.nd, r.err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    q.delete();
    send_str("123456789 ff DEADBEEF,");
    wait_results(3);
    take(r);
    checks++; if (r.err !== 1'b1 || r.word !== '0 || r.nd !== '0) begin errors++; $display("FAIL ovf_result got %h/%0d/%b want 0/0/1", r.word, r.nd, r.err); end
    take(r);
    checks++; if (r.word !== 32'h000000FF || r.nd !== 4'd2 || r.err !== 1'b0) begin errors++; $display("FAIL ff_result got %h/%0d/%b want 000000ff/2/0", r.word, r.nd, r.err); end
    take(r);
    checks++; if (r.word !== 32'hDEADBEEF || r.nd !== 4'd8 || r.err !== 1'b0) begin errors++; $display("FAIL full_width got %h/%0d/%b want deadbeef/8/0", r.word, r.nd, r.err); end
  endtask

  task automatic test_invalid();
    q.delete();
    send_str("12g4 5");
    send_byte(8'h0D);
    send_str("x ");
    wait_results(3);
    take(r);
    checks++; if (r.err !== 1'b1 || r.word !== '0 || r.nd !== '0) begin errors++; $display("FAIL inv_result got %h/%0d/%b want 0/0/1", r.word, r.nd, r.err); end
    take(r);
    checks++; if (r.word !== 32'h5 || r.nd !== 4'd1 || r.err !== 1'b0) begin errors++; $display("FAIL inv_next got %h/%0d/%b want 5/1/0", r.word, r.nd, r.err); end
    take(r);
    checks++; if (r.err !== 1'b1 || r.word !== '0) begin errors++; $display("FAIL inv_idle_x got %h/%b want 0/1", r.word, r.err); end
  endtask

  task automatic test_backpressure();
    bit held_ok = 1'b1;
    q.delete();
    out_ready = 1'b0;
    send_str("7 ");
    in_data  = "8";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_word !== 32'h7 || out_ndigits !== 4'd1 || in_ready !== 1'b0) held_ok = 1'b0;
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL bp_hold valid=%b word=%h ready=%b want 1/7/0", out_valid, out_word, in_ready); end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hs_ready got %b want 0", in_ready); end
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs valid=%b ready=%b want 0/1", out_valid, in_ready); end
    send_byte("8");
    send_byte(" ");
    wait_results(2);
    take(r);
    checks++; if (r.word !== 32'h7 || r.nd !== 4'd1 || r.err !== 1'b0) begin errors++; $display("FAIL bp_first got %h/%0d/%b want 7/1/0", r.word, r.nd, r.err); end
    take(r);
    checks++; if (r.word !== 32'h8 || r.nd !== 4'd1 || r.err !== 1'b0) begin errors++; $display("FAIL bp_second got %h/%0d/%b want 8/1/0", r.word, r.nd, r.err); end
  endtask

  task automatic test_delims_only();
    int v0;
    q.delete();
    v0 = valid_cycles;
    stall_cycles = 0;
    send_str("  ");
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_str(",,  ");
    repeat (3) @(posedge clock);
    #1;
    checks++; if (valid_cycles != v0 || q.size() != 0) begin errors++; $display("FAIL delim_no_token got %0d pulses want 0", valid_cycles - v0); end
    checks++; if (stall_cycles != 0) begin errors++; $display("FAIL delim_ready got %0d stalls want 0", stall_cycles); end
  endtask

  task automatic test_reset_mid();
    q.delete();
    send_str("AB");
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    send_str("C ");
    wait_results(1);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL rst_mid_count got %0d want 1", q.size()); end
    take(r);
    checks++; if (r.word !== 32'hC || r.nd !== 4'd1 || r.err !== 1'b0) begin errors++; $display("FAIL rst_mid_word got %h/%0d/%b want c/1/0", r.word, r.nd, r.err); end
    q.delete();
    out_ready = 1'b0;
    send_str("D ");
    checks++; if (out_valid !== 1'b1 || out_word !== 32'hD) begin errors++; $display("FAIL rst_emit_pre valid=%b word=%h want 1/d", out_valid, out_word); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0 || out_word !== '0 || out_error !== 1'b0 || out_ndigits !== '0) begin errors++; $display("FAIL rst_emit valid=%b word=%h want 0/0", out_valid, out_word); end
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rst_emit_dropped got %0d results want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_invalid();
    test_backpressure();
    test_delims_only();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
